blink_controller: RTL
=====================

BLINK_CONTROLLER -- requirements
Module: blink_controller

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1, blink rate in Hz; HALF = CLK_FREQ/(2*TICK_HZ) SHALL be >= 1, elaboration SHALL fail otherwise.
REQ-003 Parameter CHANNELS, default 4, number of output channels, >= 1.
REQ-004 Parameter COUNT_W, default 4, width of blink_count.
REQ-005 Port clk  input  1  single clock; all logic on rising edge.
REQ-006 Port reset  input  1  asynchronous, active-high reset.
REQ-007 Port start  input  1  level input; a rising edge requests a sequence.
REQ-008 Port stop  input  1  level input; aborts an active sequence.
REQ-009 Port mode  input  2  00 count, 01 chase, 10 continuous, 11 reserved (behaves as 00).
REQ-010 Port blink_count  input  COUNT_W  number of ON pulses for modes 00/01.
REQ-011 Port ch_enable  input  CHANNELS  channel mask.
REQ-012 Port out  output  CHANNELS  registered blink outputs.
REQ-013 Port tick_clk  output  1  free-running square wave at TICK_HZ, registered.
REQ-014 Port busy  output  1  high while FSM not in IDLE.
REQ-015 Port done  output  1  one-cycle pulse on normal sequence completion.

Function
REQ-016 Divider: counter 0..HALF-1, tick_clk toggles on wrap; free-running, never cleared by start/stop.
REQ-017 start_q register holds previous start; accept = start & ~start_q & (state==IDLE) & ~stop.
REQ-018 FSM states IDLE, ON, OFF; a separate phase counter 0..HALF-1 times each state, cleared on accept and on every state change.
REQ-019 On accept edge: latch mode, blink_count, ch_enable; state->ON; remaining<=blink_count; chase position<=lowest set bit of latched mask.
REQ-020 ON lasts exactly HALF cycles, then OFF exactly HALF cycles.
REQ-021 out in ON: mode 00/10 = latched mask; mode 01 = one-hot at chase position; out in OFF and IDLE = 0.
REQ-022 At end of OFF, modes 00/01: remaining decrements; if it reaches 0 then state->IDLE and done=1 for one cycle, else state->ON.
REQ-023 Mode 01: at end of OFF, chase position advances to next set bit of latched mask, wrapping from MSB to lowest set bit.
REQ-024 Mode 10: ignores blink_count, alternates ON/OFF until stop; never asserts done.
REQ-025 blink_count = 0 in modes 00/01: accept edge goes directly to IDLE with done=1 next cycle, out stays 0.
REQ-026 Latched mask all zero: timing runs normally, out stays 0, done still pulses.
REQ-027 stop high in ON/OFF: next edge state->IDLE, out=0, busy=0, no done pulse.
REQ-028 start rising edge while busy: ignored, not queued; start held high does not re-trigger.
REQ-029 Inputs mode/blink_count/ch_enable changes while busy SHALL NOT affect the running sequence.

Reset
REQ-030 reset high asynchronously forces: state IDLE, out=0, tick_clk=0, busy=0, done=0, start_q=0, divider/phase/remaining/position=0.
REQ-031 reset mid-sequence aborts without done; after release, first accept requires a fresh start rising edge.

Verification (CLK_FREQ=8, TICK_HZ=1 => HALF=4, CHANNELS=4)
REQ-032 Mode 00, count=2, mask=1011, start edge at edge 0 -> out=1011 after edges 0-3, 0 after 4-7, 1011 after 8-11, 0 after 12-15; done=1 only after edge 16; busy low from edge 16.
REQ-033 Mode 01, count=4, mask=1010 -> ON pulses show 0010,1000,0010,1000 then done.
REQ-034 Mode 10, mask=1111, stop asserted at edge 21 -> out toggles every 4 cycles until edge 21, then out=0, busy=0, no done.
REQ-035 Count=0 -> done pulse one cycle after accept, out never nonzero; start held high 50 cycles -> exactly one sequence.
REQ-036 Reset pulse during ON of mode 00 -> out, busy, tick_clk all 0 immediately; tick_clk period = 8 cycles after release.

Source files
------------

// File: rtl/blink_controller.sv
// Multi-channel LED blinker: counted, chasing or continuous ON/OFF pulse trains plus a free-running tick.
// Latency: start edge to first ON output is one clock; done pulses on the clock that ends the last OFF phase.
// Backpressure: none; start edges that arrive while busy are dropped, not queued.
module blink_controller #(
    parameter int CLK_FREQ = 50000000,
    parameter int TICK_HZ  = 1,
    parameter int CHANNELS = 4,
    parameter int COUNT_W  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [1:0]          mode,
    input  logic [COUNT_W-1:0]  blink_count,
    input  logic [CHANNELS-1:0] ch_enable,
    output logic [CHANNELS-1:0] out,
    output logic                tick_clk,
    output logic                busy,
    output logic                done
);

    localparam int HALF   = CLK_FREQ / (2 * TICK_HZ);
    localparam int HALF_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int POS_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [HALF_W-1:0] HALF_M1 = HALF_W'((HALF > 0) ? HALF - 1 : 0);

    localparam logic [1:0] M_COUNT = 2'b00;
    localparam logic [1:0] M_CHASE = 2'b01;
    localparam logic [1:0] M_CONT  = 2'b10;

    generate
        if (HALF < 1) begin : g_bad_half
            $error("blink_controller: CLK_FREQ/(2*TICK_HZ) must be at least 1");
        end
        if (CHANNELS < 1) begin : g_bad_channels
            $error("blink_controller: CHANNELS must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ON   = 2'b01,
        S_OFF  = 2'b10
    } state_t;

    state_t                state_q, state_d;
    logic [HALF_W-1:0]     div_q, div_d;
    logic                  tick_q, tick_d;
    logic                  start_q, start_d;
    logic [HALF_W-1:0]     phase_q, phase_d;
    logic [COUNT_W-1:0]    remaining_q, remaining_d;
    logic [POS_W-1:0]      pos_q, pos_d;
    logic [1:0]            mode_q, mode_d;
    logic [CHANNELS-1:0]   mask_q, mask_d;
    logic [CHANNELS-1:0]   out_q, out_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic                  phase_end;
    logic [1:0]            eff_mode;

    function automatic logic [POS_W-1:0] lowest_set(input logic [CHANNELS-1:0] m);
        logic [POS_W-1:0] r;
        r = '0;
        for (int j = CHANNELS - 1; j >= 0; j--) begin
            if (m[j]) r = POS_W'(j);
        end
        return r;
    endfunction

    // Next set bit strictly above pos, wrapping to the lowest set bit.
    function automatic logic [POS_W-1:0] next_set(input logic [CHANNELS-1:0] m,
                                                   input logic [POS_W-1:0]    pos);
        logic [POS_W-1:0] above;
        logic             found;
        above = '0;
        found = 1'b0;
        for (int j = CHANNELS - 1; j >= 0; j--) begin
            if (m[j] && (j > int'(pos))) begin
                above = POS_W'(j);
                found = 1'b1;
            end
        end
        if (found)          return above;
        else if (|m)        return lowest_set(m);
        else                return pos;
    endfunction

    assign eff_mode  = (mode == 2'b11) ? M_COUNT : mode;
    assign accept    = start & ~start_q & (state_q == S_IDLE) & ~stop;
    assign phase_end = (phase_q == HALF_M1);

    always_comb begin
        div_d       = div_q;
        tick_d      = tick_q;
        start_d     = start;
        state_d     = state_q;
        phase_d     = phase_q;
        remaining_d = remaining_q;
        pos_d       = pos_q;
        mode_d      = mode_q;
        mask_d      = mask_q;
        done_d      = 1'b0;
        out_d       = '0;

        if (div_q == HALF_M1) begin
            div_d  = '0;
            tick_d = ~tick_q;
        end else begin
            div_d = div_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                phase_d = '0;
                if (accept) begin
                    mode_d      = eff_mode;
                    mask_d      = ch_enable;
                    remaining_d = blink_count;
                    pos_d       = lowest_set(ch_enable);
                    if ((eff_mode != M_CONT) && (blink_count == '0)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_ON;
                    end
                end
            end
            S_ON: begin
                if (stop) begin
                    state_d = S_IDLE;
                    phase_d = '0;
                end else if (phase_end) begin
                    state_d = S_OFF;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_OFF: begin
                if (stop) begin
                    state_d = S_IDLE;
                    phase_d = '0;
                end else if (phase_end) begin
                    phase_d = '0;
                    if (mode_q == M_CONT) begin
                        state_d = S_ON;
                    end else begin
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q == COUNT_W'(1)) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_ON;
                            if (mode_q == M_CHASE) pos_d = next_set(mask_q, pos_q);
                        end
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase

        // Output is registered from the next-state view so ON shows on the accept edge.
        if (state_d == S_ON) begin
            if (mode_d == M_CHASE) out_d = mask_d & (CHANNELS'(1) << pos_d);
            else                   out_d = mask_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            tick_q      <= 1'b0;
            start_q     <= 1'b0;
            phase_q     <= '0;
            remaining_q <= '0;
            pos_q       <= '0;
            mode_q      <= M_COUNT;
            mask_q      <= '0;
            out_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            tick_q      <= tick_d;
            start_q     <= start_d;
            phase_q     <= phase_d;
            remaining_q <= remaining_d;
            pos_q       <= pos_d;
            mode_q      <= mode_d;
            mask_q      <= mask_d;
            out_q       <= out_d;
            done_q      <= done_d;
        end
    end

    assign out      = out_q;
    assign tick_clk = tick_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

endmodule
